// File: rtl/ocx_tlx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ocx_tlx_arb_pkg
// Description : Shared constants, lock-state encoding and index-width helper
//               for the TLX receive-FIFO drain arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ocx_tlx_arb_pkg;

    localparam int c_data_width = 514;
    localparam int c_eop_bit    = 513;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    localparam logic [0:0] c_st_idle   = IDLE;
    localparam logic [0:0] c_st_locked = LOCKED;

    // Bits needed to index 'value' entries; never narrower than one bit.
    function automatic int idx_width(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ocx_tlx_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : ocx_tlx_arb_if
// Description : FIFO-side and stream-side signal bundle of the drain arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ocx_tlx_arb_if
    import ocx_tlx_arb_pkg::*;
#(
    parameter int NUM_FIFOS  = 4,
    parameter int DATA_WIDTH = c_data_width
);
    localparam int c_idx_w = idx_width(NUM_FIFOS);

    logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_data;
    logic [NUM_FIFOS-1:0]            fifo_data_available;
    logic [NUM_FIFOS-1:0]            fifo_underflow_error;
    logic [NUM_FIFOS-1:0]            fifo_overflow_error;
    logic [NUM_FIFOS-1:0]            fifo_rd_done;
    logic [NUM_FIFOS-1:0]            port_enable;
    logic                            out_valid;
    logic [DATA_WIDTH-1:0]           out_data;
    logic                            out_ready;
    logic [c_idx_w-1:0]              out_src;
    logic [NUM_FIFOS-1:0]            err_underflow;
    logic [NUM_FIFOS-1:0]            err_overflow;
    logic                            err_timeout;

    // The arbiter side.
    modport master (
        input  fifo_data, fifo_data_available, fifo_underflow_error,
               fifo_overflow_error, port_enable, out_ready,
        output fifo_rd_done, out_valid, out_data, out_src,
               err_underflow, err_overflow, err_timeout
    );

    // The FIFO / downstream side.
    modport slave (
        output fifo_data, fifo_data_available, fifo_underflow_error,
               fifo_overflow_error, port_enable, out_ready,
        input  fifo_rd_done, out_valid, out_data, out_src,
               err_underflow, err_overflow, err_timeout
    );

endinterface
`default_nettype wire

// File: rtl/ocx_tlx_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : ocx_tlx_rr_pick
// Description : Combinational rotate-priority picker; the first request after
//               ptr (wrapping) wins.
// Revision    : 1.0 - initial release
// ============================================================================
module ocx_tlx_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    int w_pos;

    always_comb begin
        gnt_idx    = '0;
        any        = 1'b0;
        gnt_onehot = '0;
        w_pos      = 0;
        // Walk from farthest to nearest so the nearest request overwrites.
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_pos = (int'(ptr) + k) % NUM_REQ;
            if (req[w_pos]) begin
                gnt_idx = IDX_W'(w_pos);
                any     = 1'b1;
            end
        end
        if (any) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ocx_tlx_fifo_drain_arb.sv
`default_nettype none
// ============================================================================
// Module      : ocx_tlx_fifo_drain_arb
// Description : Packet-aware round-robin drain of the TLX receive FIFOs onto a
//               registered valid/ready stream, with sticky error collection.
// Revision    : 1.0 - initial release
// ============================================================================
module ocx_tlx_fifo_drain_arb
    import ocx_tlx_arb_pkg::*;
#(
    parameter int NUM_FIFOS  = 4,
    parameter int DATA_WIDTH = c_data_width,
    parameter int EOP_BIT    = c_eop_bit,
    parameter int MAX_BEATS  = 16
) (
    input  logic          clock,
    input  logic          reset,
    ocx_tlx_arb_if.master bus
);

    localparam int c_idx_w = idx_width(NUM_FIFOS);
    localparam int c_cnt_w = idx_width(MAX_BEATS + 1);

    logic [0:0]            r_state;
    logic [c_idx_w-1:0]    r_lock_idx;
    logic [c_idx_w-1:0]    r_rr_ptr;
    logic [c_cnt_w-1:0]    r_beat_cnt;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [c_idx_w-1:0]    r_out_src;
    logic [NUM_FIFOS-1:0]  r_err_underflow;
    logic [NUM_FIFOS-1:0]  r_err_overflow;
    logic                  r_err_timeout;

    logic [NUM_FIFOS-1:0]  w_req;
    logic [NUM_FIFOS-1:0]  w_pick_onehot;
    logic [c_idx_w-1:0]    w_pick_idx;
    logic                  w_pick_any;
    logic                  w_locked;
    logic [c_idx_w-1:0]    w_sel_idx;
    logic [NUM_FIFOS-1:0]  w_sel_onehot;
    logic                  w_sel_valid;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_eop;
    logic [c_cnt_w-1:0]    w_beat_next;
    logic                  w_len_hit;

    assign w_req = bus.fifo_data_available & bus.port_enable;

    ocx_tlx_rr_pick #(
        .NUM_REQ (NUM_FIFOS),
        .IDX_W   (c_idx_w)
    ) u_rr_pick (
        .req        (w_req),
        .ptr        (r_rr_ptr),
        .gnt_onehot (w_pick_onehot),
        .gnt_idx    (w_pick_idx),
        .any        (w_pick_any)
    );

    // While locked only the owning FIFO may feed the stream, enabled or not.
    always_comb begin
        w_locked     = (r_state == c_st_locked);
        w_sel_idx    = w_locked ? r_lock_idx : w_pick_idx;
        w_sel_valid  = w_locked ? bus.fifo_data_available[r_lock_idx] : w_pick_any;
        w_sel_onehot = w_locked ? (NUM_FIFOS'(1) << r_lock_idx) : w_pick_onehot;
        w_load       = (!r_out_valid || bus.out_ready) && w_sel_valid && !reset;
        w_sel_data   = bus.fifo_data[int'(w_sel_idx)*DATA_WIDTH +: DATA_WIDTH];
        w_sel_eop    = w_sel_data[EOP_BIT];
        w_beat_next  = r_beat_cnt + c_cnt_w'(1);
        w_len_hit    = (w_beat_next == c_cnt_w'(MAX_BEATS));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= c_st_idle;
            r_lock_idx      <= '0;
            r_rr_ptr        <= '0;
            r_beat_cnt      <= '0;
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_out_src       <= '0;
            r_err_underflow <= '0;
            r_err_overflow  <= '0;
            r_err_timeout   <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_src   <= w_sel_idx;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            r_err_underflow <= r_err_underflow | bus.fifo_underflow_error;
            r_err_overflow  <= r_err_overflow  | bus.fifo_overflow_error;

            if (w_load) begin
                case (r_state)
                    c_st_idle: begin
                        r_rr_ptr <= w_sel_idx;
                        if (!w_sel_eop) begin
                            r_state    <= c_st_locked;
                            r_lock_idx <= w_sel_idx;
                            r_beat_cnt <= c_cnt_w'(1);
                        end
                    end
                    default: begin
                        // An over-long packet still delivers its last beat.
                        if (w_sel_eop) begin
                            r_state    <= c_st_idle;
                            r_beat_cnt <= '0;
                        end else if (w_len_hit) begin
                            r_err_timeout <= 1'b1;
                            r_state       <= c_st_idle;
                            r_beat_cnt    <= '0;
                        end else begin
                            r_beat_cnt <= w_beat_next;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.fifo_rd_done  = w_load ? w_sel_onehot : '0;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_data      = r_out_data;
    assign bus.out_src       = r_out_src;
    assign bus.err_underflow = r_err_underflow;
    assign bus.err_overflow  = r_err_overflow;
    assign bus.err_timeout   = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ocx_tlx_fifo_drain_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ocx_tlx_fifo_drain_arb
// Description : Directed bench for the drain arbiter with simple FIFO models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ocx_tlx_fifo_drain_arb;
    import ocx_tlx_arb_pkg::*;

    localparam int NF = 4;
    localparam int DW = 514;
    localparam int MB = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;

    ocx_tlx_arb_if #(.NUM_FIFOS(NF), .DATA_WIDTH(DW)) bus ();

    ocx_tlx_fifo_drain_arb #(
        .NUM_FIFOS  (NF),
        .DATA_WIDTH (DW),
        .EOP_BIT    (513),
        .MAX_BEATS  (MB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] mem [NF][64];
    int            wp [NF];
    int            rp [NF];
    logic [NF-1:0] rd_snap;
    int            vectors;
    int            miscompares;
    int            rr_order [4];

    function automatic logic [DW-1:0] mk(input logic eop, input logic [15:0] tag);
        return {eop, 1'b0, {32{tag}}};
    endfunction

    task automatic refresh();
        for (int i = 0; i < NF; i++) begin
            bus.fifo_data_available[i] = (wp[i] != rp[i]);
            bus.fifo_data[i*DW +: DW]  = (wp[i] != rp[i]) ? mem[i][rp[i] % 64] : '0;
        end
    endtask

    task automatic push(input int f, input logic [DW-1:0] beat);
        mem[f][wp[f] % 64] = beat;
        wp[f] = wp[f] + 1;
        refresh();
    endtask

    // One clock: capture the pop strobes that the coming edge acts on, then pop.
    task automatic tick();
        @(negedge clock);
        rd_snap = bus.fifo_rd_done;
        @(posedge clock);
        #1;
        for (int i = 0; i < NF; i++) begin
            if (rd_snap[i] && (wp[i] != rp[i])) rp[i] = rp[i] + 1;
        end
        refresh();
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input int src, input logic [DW-1:0] data);
        check({tag, ".rd_done"}, DW'(rd_snap), DW'(1) << src);
        check({tag, ".valid"}, DW'(bus.out_valid), DW'(1));
        check({tag, ".src"}, DW'(bus.out_src), DW'(src));
        check({tag, ".data"}, bus.out_data, data);
    endtask

    task automatic idle(input string tag);
        check({tag, ".rd_done"}, DW'(rd_snap), '0);
        check({tag, ".valid"}, DW'(bus.out_valid), '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rr_order    = '{1, 2, 3, 0};
        for (int i = 0; i < NF; i++) begin
            wp[i] = 0;
            rp[i] = 0;
        end
        bus.fifo_data            = '0;
        bus.fifo_data_available  = '0;
        bus.fifo_underflow_error = '0;
        bus.fifo_overflow_error  = '0;
        bus.port_enable          = 4'b1111;
        bus.out_ready            = 1'b1;
        refresh();

        // Reset state
        tick();
        tick();
        check("rst.valid", DW'(bus.out_valid), '0);
        check("rst.data", bus.out_data, '0);
        check("rst.src", DW'(bus.out_src), '0);
        check("rst.rd_done", DW'(rd_snap), '0);
        check("rst.err_uf", DW'(bus.err_underflow), '0);
        check("rst.err_of", DW'(bus.err_overflow), '0);
        check("rst.err_to", DW'(bus.err_timeout), '0);
        reset = 1'b0;

        // Single-beat packets rotate 1,2,3,0 starting after rr_ptr=0
        for (int f = 0; f < NF; f++) push(f, mk(1'b1, 16'h0010 + 16'(f)));
        for (int k = 0; k < 4; k++) begin
            tick();
            beat("rr", rr_order[k], mk(1'b1, 16'h0010 + 16'(rr_order[k])));
        end
        tick();
        idle("rr.drain");

        // Packet lock: FIFO0 three beats, FIFO1 waits
        push(0, mk(1'b0, 16'h0020));
        push(0, mk(1'b0, 16'h0021));
        push(0, mk(1'b1, 16'h0022));
        tick();
        beat("lock.b0", 0, mk(1'b0, 16'h0020));
        push(1, mk(1'b1, 16'h0030));
        tick();
        beat("lock.b1", 0, mk(1'b0, 16'h0021));
        tick();
        beat("lock.b2", 0, mk(1'b1, 16'h0022));
        tick();
        beat("lock.next", 1, mk(1'b1, 16'h0030));
        tick();
        idle("lock.drain");

        // Backpressure mid-packet on FIFO2
        for (int k = 0; k < 4; k++) push(2, mk(k == 3, 16'h0040 + 16'(k)));
        tick();
        beat("bp.b0", 2, mk(1'b0, 16'h0040));
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp.hold.rd_done", DW'(rd_snap), '0);
            check("bp.hold.valid", DW'(bus.out_valid), DW'(1));
            check("bp.hold.data", bus.out_data, mk(1'b0, 16'h0040));
        end
        bus.out_ready = 1'b1;
        tick();
        beat("bp.b1", 2, mk(1'b0, 16'h0041));
        tick();
        beat("bp.b2", 2, mk(1'b0, 16'h0042));
        tick();
        beat("bp.b3", 2, mk(1'b1, 16'h0043));
        tick();
        idle("bp.drain");

        // Timeout: 17 beats with no EOP on FIFO2, FIFO3 waiting
        for (int k = 0; k < 17; k++) push(2, mk(1'b0, 16'h0100 + 16'(k)));
        tick();
        beat("to.b0", 2, mk(1'b0, 16'h0100));
        push(3, mk(1'b1, 16'h0050));
        for (int k = 1; k < 16; k++) begin
            tick();
            beat("to.bn", 2, mk(1'b0, 16'h0100 + 16'(k)));
            check("to.flag", DW'(bus.err_timeout), DW'(k == 15));
        end
        tick();
        beat("to.rr", 3, mk(1'b1, 16'h0050));
        tick();
        beat("to.b16", 2, mk(1'b0, 16'h0110));
        push(0, mk(1'b1, 16'h0060));
        tick();
        idle("to.stall");
        push(2, mk(1'b1, 16'h0111));
        tick();
        beat("to.eop", 2, mk(1'b1, 16'h0111));
        tick();
        beat("to.f0", 0, mk(1'b1, 16'h0060));
        tick();
        idle("to.drain");
        check("to.sticky", DW'(bus.err_timeout), DW'(1));

        // port_enable masks new packets only
        bus.port_enable = 4'b1101;
        push(1, mk(1'b1, 16'h0070));
        push(3, mk(1'b1, 16'h0071));
        tick();
        beat("pe.f3", 3, mk(1'b1, 16'h0071));
        tick();
        idle("pe.block0");
        tick();
        idle("pe.block1");
        bus.port_enable = 4'b1111;
        tick();
        beat("pe.f1", 1, mk(1'b1, 16'h0070));
        tick();
        idle("pe.drain");
        push(1, mk(1'b0, 16'h0080));
        push(1, mk(1'b0, 16'h0081));
        push(1, mk(1'b1, 16'h0082));
        tick();
        beat("pe.m0", 1, mk(1'b0, 16'h0080));
        bus.port_enable = 4'b1101;
        tick();
        beat("pe.m1", 1, mk(1'b0, 16'h0081));
        tick();
        beat("pe.m2", 1, mk(1'b1, 16'h0082));
        tick();
        idle("pe.mdrain");
        bus.port_enable = 4'b1111;

        // Sticky error flags
        bus.fifo_overflow_error = 4'b1000;
        tick();
        bus.fifo_overflow_error = 4'b0000;
        check("err.of", DW'(bus.err_overflow), DW'(4'b1000));
        tick();
        check("err.of.sticky", DW'(bus.err_overflow), DW'(4'b1000));
        bus.fifo_underflow_error = 4'b0001;
        tick();
        bus.fifo_underflow_error = 4'b0000;
        tick();
        check("err.uf", DW'(bus.err_underflow), DW'(4'b0001));
        check("err.of.hold", DW'(bus.err_overflow), DW'(4'b1000));

        // Reset while locked on FIFO0
        push(0, mk(1'b0, 16'h0090));
        push(0, mk(1'b1, 16'h0091));
        tick();
        beat("rl.b0", 0, mk(1'b0, 16'h0090));
        reset = 1'b1;
        tick();
        check("rl.rd_done", DW'(rd_snap), '0);
        check("rl.valid", DW'(bus.out_valid), '0);
        check("rl.data", bus.out_data, '0);
        check("rl.src", DW'(bus.out_src), '0);
        check("rl.err_uf", DW'(bus.err_underflow), '0);
        check("rl.err_of", DW'(bus.err_overflow), '0);
        check("rl.err_to", DW'(bus.err_timeout), '0);
        for (int i = 0; i < NF; i++) rp[i] = wp[i];
        refresh();
        reset = 1'b0;
        tick();
        idle("rl.empty");
        push(1, mk(1'b1, 16'h00a0));
        tick();
        beat("rl.unlocked", 1, mk(1'b1, 16'h00a0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ocx_tlx_fifo_drain_arb.md
Name: ocx_tlx_fifo_drain_arb

Overview:
- Packet-aware round-robin arbiter draining NUM_FIFOS 514x16 receive FIFOs onto one registered 514-bit output stream with valid/ready handshake.
- Sits between the TLX per-virtual-channel 514x16 FIFOs and the downstream parser; generates each FIFO's rd_done pop strobe.
- Aggregates the FIFOs' underflow/overflow flags into sticky error status.

Parameters:
- NUM_FIFOS, 4, number of FIFOs arbitrated (2..8).
- DATA_WIDTH, 514, beat width; must match the FIFO width.
- EOP_BIT, 513, bit index of the end-of-packet marker within a beat.
- MAX_BEATS, 16, longest legal packet in beats; exceeding it raises a timeout error and releases the lock.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- fifo_data  in  NUM_FIFOS*DATA_WIDTH  head-of-FIFO data; FIFO i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- fifo_data_available  in  NUM_FIFOS  head data valid, per FIFO.
- fifo_underflow_error  in  NUM_FIFOS  FIFO error pulses.
- fifo_overflow_error  in  NUM_FIFOS  FIFO error pulses.
- fifo_rd_done  out  NUM_FIFOS  one-hot pop strobe to FIFO i.
- port_enable  in  NUM_FIFOS  FIFO may start a new packet when 1.
- out_valid  out  1  output beat valid.
- out_data  out  DATA_WIDTH  output beat.
- out_ready  in  1  downstream accepts the beat.
- out_src  out  log2(NUM_FIFOS)  source FIFO index of out_data.
- err_underflow  out  NUM_FIFOS  sticky per-FIFO underflow.
- err_overflow  out  NUM_FIFOS  sticky per-FIFO overflow.
- err_timeout  out  1  sticky packet-length timeout.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_src=0, fifo_rd_done=0, all err_* =0, lock=0, rr_ptr=0, beat_cnt=0.
- Load condition: load = can_load && sel_valid, where can_load = !out_valid || out_ready.
- Unlocked selection: sel = first FIFO i, searching from rr_ptr+1 with wrap modulo NUM_FIFOS, that has fifo_data_available[i] && port_enable[i].
- Locked selection: sel = locked index only, with sel_valid = fifo_data_available[lock_idx]; port_enable is ignored while locked.
- On load (same cycle): fifo_rd_done[sel]=1.
- On load (next cycle): out_data = fifo_data[sel], out_src = sel, out_valid = 1. Latency is 1 cycle from FIFO head to out_valid.
- Sustained throughput is 1 beat per cycle when out_ready is held high.
- No load but out_ready=1: out_valid drops to 0. out_data holds its value whenever out_valid=1 && !out_ready.
- fifo_rd_done is never asserted unless fifo_data_available of that FIFO is 1. At most one bit is set per cycle.
- Lock FSM has two states, IDLE and LOCKED.
  - IDLE to LOCKED: load a beat with EOP_BIT=0. Record lock_idx=sel, set rr_ptr=sel, set beat_cnt=1.
  - IDLE, load with EOP=1 (single-beat packet): stay IDLE, set rr_ptr=sel.
  - LOCKED: each load increments beat_cnt. A load with EOP=1 returns to IDLE.
  - LOCKED, beat_cnt reaches MAX_BEATS without EOP: set err_timeout, return to IDLE. That last beat is still delivered.
  - LOCKED with the locked FIFO empty: stall. Other FIFOs are never granted mid-packet.
- Sticky errors: err_underflow[i] and err_overflow[i] are set on the corresponding input pulse. They, and err_timeout, clear only on reset.
- Reset mid-packet: lock and output are discarded immediately. The FIFOs are reset on the same reset, so no partial state persists.

Decomposition:
- Shared package ocx_tlx_arb_pkg holds: the DATA_WIDTH/EOP_BIT constants, the lock-state enum {IDLE, LOCKED}, and a clog2 helper for the index width.
- One sub-module, ocx_tlx_rr_pick: combinational rotate-priority one-hot picker taking (req, ptr) and returning (gnt_onehot, gnt_idx, any).

Test Plan:
- Single-beat round-robin: all four FIFOs each hold one EOP=1 beat, out_ready=1 → out_src sequence 1,2,3,0; rd_done one-hot, one per cycle.
- Packet lock: FIFO0 holds a 3-beat packet (EOP on beat 3) and FIFO1 has data → out_src = 0,0,0 then 1; FIFO1's rd_done stays low during FIFO0's beats.
- Backpressure: out_ready=0 for 5 cycles mid-packet → out_data stable, no rd_done pulses; resume gives no loss or duplicate (check beat payload counter values).
- Timeout: FIFO2 sends 17 beats with no EOP, MAX_BEATS=16 → err_timeout=1 after beat 16 is loaded; the next grant is rr-selected; beat 17 is treated as a new packet.
- port_enable: port_enable=4'b1101 with FIFO1 holding data → FIFO1 is never granted. Clear port_enable[1] mid-packet on FIFO1 → that packet completes.
- Errors/reset: pulse fifo_overflow_error[3] → err_overflow=4'b1000, sticky. Assert reset in the LOCKED state → all outputs return to 0 the next cycle.
